// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store bus access unit: size codes, FSM states,
// byte-enable patterns and the store lane-placement helpers.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] be_for(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = BE_BYTE0 << off;
            SZ_HALF: be = off[1] ? BE_HALF_HI : BE_HALF_LO;
            SZ_WORD: be = BE_WORD;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

    // Sub-word stores are replicated so the slave can pick any lane via bus_be.
    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] placed;
        case (sz)
            SZ_BYTE: placed = {4{wd[7:0]}};
            SZ_HALF: placed = {2{wd[15:0]}};
            default: placed = wd;
        endcase
        return placed;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Extracts the addressed byte/half/word from a bus read word and sign- or
// zero-extends it to 32 bits.
module load_formatter
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_word,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = rdata_word >> {byte_off, 3'b000};

    // NOTE: every path assigns load_data, so no latch is inferred here.
    always_comb begin
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            SZ_WORD: load_data = shifted;
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns a core memory request into a single registered bus
// transaction, stalling the pipeline until ack or timeout.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        load_signed,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [1:0]  lat_off;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] fmt_data;
    logic        req_any;
    logic        illegal;

    assign req_any = mem_read | mem_write;

    always_comb begin
        illegal = mem_read & mem_write;
        case (size)
            SZ_BYTE: ;
            SZ_HALF: if (addr[0]) illegal = 1'b1;
            SZ_WORD: if (addr[1:0] != 2'b00) illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        align_err = 1'b0;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        align_err = illegal;
                        stall     = ~illegal;
                    end
                end
                ST_BUSY: stall = 1'b1;
                default: ;
            endcase
        end
    end

    load_formatter u_load_formatter (
        .rdata_word (bus_rdata),
        .byte_off   (lat_off),
        .size       (lat_size),
        .sign_ext   (lat_signed),
        .load_data  (fmt_data)
    );

    // NOTE: all state and registered outputs use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0000_0000;
            bus_be     <= BE_NONE;
            bus_wdata  <= 32'h0000_0000;
            rdata      <= 32'h0000_0000;
            bus_err    <= 1'b0;
            wait_cnt   <= 8'd0;
            lat_off    <= 2'b00;
            lat_size   <= SZ_BYTE;
            lat_signed <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_any && !illegal) begin
                        state      <= ST_BUSY;
                        bus_req    <= 1'b1;
                        bus_we     <= mem_write;
                        bus_addr   <= {addr[31:2], 2'b00};
                        bus_be     <= be_for(size, addr[1:0]);
                        bus_wdata  <= lane_wdata(size, wdata);
                        wait_cnt   <= 8'd0;
                        lat_off    <= addr[1:0];
                        lat_size   <= size;
                        lat_signed <= load_signed;
                    end
                end
                ST_BUSY: begin
                    // An ack arriving on the timeout cycle still completes normally.
                    if (bus_ack) begin
                        state   <= ST_DONE;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        rdata   <= fmt_data;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= ST_DONE;
                        bus_req  <= 1'b0;
                        bus_we   <= 1'b0;
                        bus_err  <= 1'b1;
                        rdata    <= 32'h0000_0000;
                        wait_cnt <= wait_cnt + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: MAX_WAIT, default 16, meaning max BUSY cycles allowed without bus_ack before timeout (legal range 2..255).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: mem_read  in  1  core requests a load this instruction.
REQ-005 Port: mem_write  in  1  core requests a store this instruction.
REQ-006 Port: addr  in  32  byte address (ALU result).
REQ-007 Port: wdata  in  32  store data (rt register value).
REQ-008 Port: size  in  2  access size: 0 byte, 1 half, 2 word; 3 is illegal.
REQ-009 Port: load_signed  in  1  1 sign-extends, 0 zero-extends sub-word loads.
REQ-010 Port: stall  out  1  holds PC and pipeline state while high.
REQ-011 Port: rdata  out  32  formatted load data, valid while state is DONE.
REQ-012 Port: align_err  out  1  one-cycle pulse on an illegal or misaligned request.
REQ-013 Port: bus_err  out  1  one-cycle pulse on timeout.
REQ-014 Port: bus_req / bus_we  out  1 / 1  external bus request and write strobe.
REQ-015 Port: bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-016 Port: bus_be / bus_wdata  out  4 / 32  byte enables and lane-placed store data.
REQ-017 Port: bus_rdata / bus_ack  in  32 / 1  read word and completion strobe.

Function
REQ-018 FSM states SHALL be IDLE, BUSY and DONE; bus_* outputs SHALL be registered; stall and align_err SHALL be combinational from state and inputs.
REQ-019 In IDLE, a legal request SHALL assert stall in the same cycle, latch addr/size/sign/we/be/wdata and move to BUSY.
REQ-020 A request is illegal when mem_read&mem_write, size==3, size==1 with addr[0]=1, or size==2 with addr[1:0]!=0; in that case the unit SHALL pulse align_err, keep stall low, stay in IDLE and issue no bus cycle.
REQ-021 In BUSY, bus_req SHALL be 1 and stall 1; bus_addr, bus_we, bus_be and bus_wdata SHALL hold stable until exit.
REQ-022 Byte enables: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
REQ-023 bus_wdata: byte replicated into all 4 lanes; half replicated into both halves; word unchanged.
REQ-024 On bus_ack in BUSY, the unit SHALL register the formatted load data (bus_rdata>>8*addr[1:0], truncated to size, then extended per load_signed) into rdata and move to DONE.
REQ-025 A per-request wait counter SHALL clear on IDLE->BUSY and increment each BUSY cycle without ack; at count MAX_WAIT the unit SHALL pulse bus_err, set rdata=0 and move to DONE.
REQ-026 bus_ack in the same cycle as the timeout SHALL win: no bus_err, and the data is taken.
REQ-027 In DONE, stall SHALL be 0, bus_req SHALL be 0, and the next state SHALL be IDLE unconditionally.
REQ-028 Minimum latency: request cycle 0, bus_req cycle 1, ack cycle 1, stall low in cycle 2; that is, stall is high for 2 cycles.
REQ-029 bus_ack in IDLE or DONE SHALL be ignored.
REQ-030 In IDLE with no request, stall=0 and bus_req=0.

Reset
REQ-031 While reset is high, the following SHALL hold on the next edge: state IDLE, bus_req 0, bus_we 0, bus_be 0, bus_addr 0, bus_wdata 0, rdata 0, counter 0, bus_err 0.
REQ-032 Reset asserted during BUSY SHALL abandon the transaction, with bus_req low after that edge; any late bus_ack SHALL be ignored.
REQ-033 While reset is high, stall and align_err SHALL be forced to 0.

Structure
REQ-034 A shared package mem_access_pkg SHALL hold the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), the state enum and the BE constants.
REQ-035 One combinational sub-module, load_formatter (inputs rdata word, addr[1:0], size, signed; output 32-bit), SHALL perform load extraction.

Verification
REQ-036 Word store: addr=0x0000_0008, wdata=0x1234_5678, size=2, ack on first BUSY cycle -> bus_addr=0x8, be=1111, stall high exactly 2 cycles.
REQ-037 Signed byte load: addr=0x3, bus_rdata=0x80FF_0011, load_signed=1 -> rdata=0xFFFF_FF80; with load_signed=0 -> rdata=0x0000_0080.
REQ-038 Half store: addr=0x6, wdata=0x0000_BEEF -> be=1100, bus_wdata=0xBEEF_BEEF.
REQ-039 Misaligned word load: addr=0x2 -> align_err pulses 1 cycle, bus_req never asserted, stall stays 0.
REQ-040 Timeout: MAX_WAIT=4, no ack -> bus_err pulse after the 4th BUSY cycle, rdata=0; repeat with ack on that same cycle -> no bus_err.
REQ-041 Reset asserted on the 2nd BUSY cycle -> bus_req=0 next cycle, state IDLE, a following ack is ignored.
